// File: rtl/seq_shift_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit retired per clock, signed/unsigned at runtime.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as no set multiplier bits remain.
module seq_shift_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic signed [PW-1:0]   mcand_sh;
  logic signed [PW-1:0]   acc;
  logic signed [PW-1:0]   acc_nxt;
  logic [WIDTH-1:0]       b_sh;
  logic                   smode;
  logic [CNT_W-1:0]       cnt;
  logic                   msb_iter;
  logic                   last_iter;

  function automatic logic signed [PW-1:0] extend_operand(input logic [WIDTH-1:0] v,
                                                          input logic s);
    extend_operand = {{WIDTH{s & v[WIDTH-1]}}, v};
  endfunction

  // The MSB of a two's-complement multiplier carries weight -2^(WIDTH-1), so it subtracts.
  always_comb begin
    msb_iter = (cnt == CNT_W'(WIDTH - 1));
    acc_nxt  = acc;
    if (b_sh[0])
      acc_nxt = (smode && msb_iter) ? acc - mcand_sh : acc + mcand_sh;
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_iter = msb_iter || (b_sh[WIDTH-1:1] == '0);
`else
  assign last_iter = msb_iter;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
      acc      <= '0;
      mcand_sh <= '0;
      b_sh     <= '0;
      smode    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_sh <= extend_operand(a, signed_mode);
            b_sh     <= b;
            smode    <= signed_mode;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          done     <= 1'b0;
          acc      <= acc_nxt;
          mcand_sh <= mcand_sh << 1;
          b_sh     <= b_sh >> 1;
          cnt      <= cnt + 1'b1;
          if (last_iter) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          p    <= acc;
          // A start here chains straight into the next operation.
          if (start) begin
            mcand_sh <= extend_operand(a, signed_mode);
            b_sh     <= b;
            smode    <= signed_mode;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
